// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared command codes and FSM state encoding for the RV32 run
//            controller. The state values also appear on the debug pins.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_LOAD = 3'd1;
    localparam logic [2:0] CMD_RUN  = 3'd2;
    localparam logic [2:0] CMD_HALT = 3'd3;
    localparam logic [2:0] CMD_STEP = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_HALT = 3'd3,
        ST_STEP = 3'd4
    } state_t;

    // Core is out of reset in these states.
    function automatic logic core_released(state_t s);
        return (s == ST_RUN) || (s == ST_HALT) || (s == ST_STEP);
    endfunction

    // Pipeline advances in these states.
    function automatic logic core_enabled(state_t s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_run_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_controller_if
// Purpose  : Bundles the host command/byte inputs and the IMEM/core control
//            outputs of the run controller.
// Ports    : master - host side (drives cmd/data, observes status)
//            slave  - controller side
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_run_controller_if #(
    parameter int WIDTH   = 32,
    parameter int IMEM_AW = 6,
    parameter int CNT_W   = 16
) ();
    logic               cmd_valid;
    logic [2:0]         cmd;
    logic               data_valid;
    logic [7:0]         data_in;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [WIDTH-1:0]   imem_wdata;
    logic               cpu_rst;
    logic               cpu_en;
    logic [2:0]         state;
    logic               overflow;
    logic [CNT_W-1:0]   run_cycles;

    modport master (
        output cmd_valid, cmd, data_valid, data_in,
        input  imem_we, imem_waddr, imem_wdata, cpu_rst, cpu_en,
               state, overflow, run_cycles
    );

    modport slave (
        input  cmd_valid, cmd, data_valid, data_in,
        output imem_we, imem_waddr, imem_wdata, cpu_rst, cpu_en,
               state, overflow, run_cycles
    );
endinterface
`default_nettype wire

// File: rtl/byte_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : byte_word_assembler
// Purpose  : Packs bytes little-endian into WIDTH-bit words and emits a
//            registered one-cycle write pulse per completed (or flushed,
//            zero-padded) word.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            clear        - drop any partial word, index back to lane 0
//            byte_in/valid- incoming byte and its strobe
//            flush        - write out a partial word now
//            word/we      - registered word and write pulse
//            fire         - combinational: a write is issued this edge
// Revision : 1.0 - initial release
// ============================================================================
module byte_word_assembler #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    input  wire logic [7:0]       byte_in,
    input  wire logic             valid,
    input  wire logic             flush,
    output logic      [WIDTH-1:0] word,
    output logic                  we,
    output logic                  fire
);
    localparam int LANES = WIDTH / 8;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] r_word;
    logic [IDX_W-1:0] r_idx;
    logic             r_we;
    logic             w_last;
    logic             w_fire;

    // The accumulator is zeroed after every write, so a flushed partial
    // word is automatically zero-padded in its unfilled upper lanes.
    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < LANES; i++) begin
            if (valid && (r_idx == IDX_W'(i))) begin
                w_acc_next[i*8 +: 8] = byte_in;
            end
        end
    end

    // A byte arriving with flush is consumed first; if it completes the
    // word this is still a single write.
    assign w_last = valid && (r_idx == IDX_W'(LANES - 1));
    assign w_fire = w_last || (flush && (valid || (r_idx != '0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_idx  <= '0;
            r_word <= '0;
            r_we   <= 1'b0;
        end else if (clear) begin
            r_acc  <= '0;
            r_idx  <= '0;
            r_we   <= 1'b0;
        end else begin
            r_we <= w_fire;
            if (w_fire) begin
                r_word <= w_acc_next;
                r_acc  <= '0;
                r_idx  <= '0;
            end else if (valid) begin
                r_acc  <= w_acc_next;
                r_idx  <= r_idx + IDX_W'(1);
            end
        end
    end

    assign word = r_word;
    assign we   = r_we;
    assign fire = w_fire;

endmodule
`default_nettype wire

// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_controller
// Purpose  : Bring-up sequencer for the pipelined RV32 core. Loads program
//            bytes into IMEM while the core is held in reset, then provides
//            RUN / HALT / single-STEP control and a saturating cycle counter.
// Ports    : clk, rst - clock, synchronous active-high reset
//            bus      - slave side of cpu_run_controller_if:
//                       cmd_valid/cmd, data_valid/data_in (host inputs),
//                       imem_we/imem_waddr/imem_wdata (IMEM write port),
//                       cpu_rst/cpu_en (core control), state, overflow,
//                       run_cycles (status)
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int IMEM_AW = 6,
    parameter int CNT_W   = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cpu_run_controller_if.slave bus
);
    state_t             r_state;
    state_t             w_next;

    logic               w_byte_ok;
    logic               w_flush;
    logic               w_load_entry;
    logic               w_fire;
    logic               w_we;
    logic [WIDTH-1:0]   w_word;

    logic [IMEM_AW-1:0] r_addr;
    logic               r_full;
    logic [IMEM_AW-1:0] r_waddr;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cpu_rst;
    logic               r_cpu_en;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid && (bus.cmd == CMD_LOAD)) w_next = ST_LOAD;
                if (bus.cmd_valid && (bus.cmd == CMD_RUN))  w_next = ST_RUN;
            end
            ST_LOAD: begin
                if (bus.cmd_valid && (bus.cmd == CMD_RUN))  w_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.cmd_valid && (bus.cmd == CMD_HALT)) w_next = ST_HALT;
                if (bus.cmd_valid && (bus.cmd == CMD_LOAD)) w_next = ST_LOAD;
            end
            ST_HALT: begin
                if (bus.cmd_valid && (bus.cmd == CMD_RUN))  w_next = ST_RUN;
                if (bus.cmd_valid && (bus.cmd == CMD_STEP)) w_next = ST_STEP;
                if (bus.cmd_valid && (bus.cmd == CMD_LOAD)) w_next = ST_LOAD;
            end
            ST_STEP: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_load_entry = (w_next == ST_LOAD) && (r_state != ST_LOAD);
    assign w_byte_ok    = (r_state == ST_LOAD) && bus.data_valid && !r_full;
    assign w_flush      = (r_state == ST_LOAD) && bus.cmd_valid && (bus.cmd == CMD_RUN);

    // ---------------- Byte packing ----------------
    byte_word_assembler #(
        .WIDTH (WIDTH)
    ) u_asm (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_load_entry),
        .byte_in (bus.data_in),
        .valid   (w_byte_ok),
        .flush   (w_flush),
        .word    (w_word),
        .we      (w_we),
        .fire    (w_fire)
    );

    // ---------------- Address, status, core control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_full    <= 1'b0;
            r_waddr   <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_cpu_rst <= 1'b1;
            r_cpu_en  <= 1'b0;
        end else begin
            // A final write issued on the RUN edge keeps the core in reset
            // for that one cycle so IMEM is never written under a live core.
            r_cpu_rst <= !core_released(w_next) || w_fire;
            r_cpu_en  <= core_enabled(w_next) && !w_fire;

            if (w_load_entry) begin
                r_addr <= '0;
                r_full <= 1'b0;
                r_ovf  <= 1'b0;
                r_cnt  <= '0;
            end else begin
                if (w_fire) begin
                    r_waddr <= r_addr;
                    // Top address is terminal: no wrap, later bytes drop.
                    if (r_addr == '1) begin
                        r_full <= 1'b1;
                    end else begin
                        r_addr <= r_addr + IMEM_AW'(1);
                    end
                end
                if ((r_state == ST_LOAD) && bus.data_valid && r_full) begin
                    r_ovf <= 1'b1;
                end
                // Counts cycles during which cpu_en was high.
                if (r_cpu_en && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.imem_we    = w_we;
    assign bus.imem_waddr = r_waddr;
    assign bus.imem_wdata = w_word;
    assign bus.cpu_rst    = r_cpu_rst;
    assign bus.cpu_en     = r_cpu_en;
    assign bus.state      = r_state;
    assign bus.overflow   = r_ovf;
    assign bus.run_cycles = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_controller
// Purpose  : Self-checking bench for cpu_run_controller: directed bring-up
//            scenarios followed by randomized commands/bytes, compared each
//            cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_controller;
    import cpu_ctrl_pkg::*;

    localparam int WIDTH   = 32;
    localparam int IMEM_AW = 2;
    localparam int CNT_W   = 6;
    localparam int DEPTH   = 1 << IMEM_AW;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int LANES   = WIDTH / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_run_controller_if #(.WIDTH(WIDTH), .IMEM_AW(IMEM_AW), .CNT_W(CNT_W)) bus ();

    cpu_run_controller #(
        .WIDTH   (WIDTH),
        .IMEM_AW (IMEM_AW),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- Behavioural model ----------------
    int          m_state;
    logic        m_cpu_rst, m_cpu_en, m_we, m_ovf;
    int          m_waddr;
    logic [31:0] m_wdata;
    int          m_cnt;
    int          m_next_addr;
    bit          m_full;
    logic [7:0]  m_q[$];

    // Observed IMEM writes, for directed checks.
    int          log_addr[$];
    logic [31:0] log_data[$];

    task automatic model_step(input bit r, input bit cv, input logic [2:0] c,
                              input bit dv, input logic [7:0] d);
        int          cur;
        int          nxt;
        bit          wrote;
        logic [31:0] w;
        if (r) begin
            m_state = 0; m_cpu_rst = 1'b1; m_cpu_en = 1'b0; m_we = 1'b0;
            m_waddr = 0; m_wdata = '0; m_ovf = 1'b0; m_cnt = 0;
            m_next_addr = 0; m_full = 1'b0; m_q.delete();
            return;
        end
        cur   = m_state;
        wrote = 1'b0;
        if (cur == 1) begin
            if (dv) begin
                if (m_full) m_ovf = 1'b1;
                else        m_q.push_back(d);
            end
            if (m_q.size() == LANES || (cv && c == CMD_RUN && m_q.size() > 0)) begin
                w = '0;
                foreach (m_q[i]) w = w | (32'(m_q[i]) << (8 * i));
                m_wdata = w;
                m_waddr = m_next_addr;
                wrote   = 1'b1;
                m_q.delete();
                if (m_next_addr == DEPTH - 1) m_full = 1'b1;
                else                          m_next_addr++;
            end
        end
        nxt = cur;
        case (cur)
            0: if (cv && c == CMD_LOAD) nxt = 1; else if (cv && c == CMD_RUN) nxt = 2;
            1: if (cv && c == CMD_RUN) nxt = 2;
            2: if (cv && c == CMD_HALT) nxt = 3; else if (cv && c == CMD_LOAD) nxt = 1;
            3: if (cv && c == CMD_RUN) nxt = 2;
               else if (cv && c == CMD_STEP) nxt = 4;
               else if (cv && c == CMD_LOAD) nxt = 1;
            default: nxt = 3;
        endcase
        if (m_cpu_en && m_cnt < CNT_MAX) m_cnt++;
        if (nxt == 1 && cur != 1) begin
            m_next_addr = 0; m_full = 1'b0; m_ovf = 1'b0; m_cnt = 0; m_q.delete();
        end
        m_we      = wrote;
        m_state   = nxt;
        m_cpu_rst = (nxt <= 1) || wrote;
        m_cpu_en  = (nxt == 2 || nxt == 4) && !wrote;
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge.
    task automatic tick(input bit r, input bit cv, input logic [2:0] c,
                        input bit dv, input logic [7:0] d);
        rst            = r;
        bus.cmd_valid  = cv;
        bus.cmd        = c;
        bus.data_valid = dv;
        bus.data_in    = d;
        model_step(r, cv, c, dv, d);
        @(posedge clk);
        #1;
        check("state",      64'(bus.state),      64'(m_state));
        check("cpu_rst",    64'(bus.cpu_rst),    64'(m_cpu_rst));
        check("cpu_en",     64'(bus.cpu_en),     64'(m_cpu_en));
        check("imem_we",    64'(bus.imem_we),    64'(m_we));
        check("imem_waddr", 64'(bus.imem_waddr), 64'(m_waddr));
        check("imem_wdata", 64'(bus.imem_wdata), 64'(m_wdata));
        check("overflow",   64'(bus.overflow),   64'(m_ovf));
        check("run_cycles", 64'(bus.run_cycles), 64'(m_cnt));
        if (bus.imem_we === 1'b1) begin
            check("we_core_in_reset", 64'(bus.cpu_rst), 64'd1);
            log_addr.push_back(int'(bus.imem_waddr));
            log_data.push_back(bus.imem_wdata);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, CMD_NOP, 1'b0, 8'h00);
    endtask

    task automatic send_cmd(input logic [2:0] c);
        tick(1'b0, 1'b1, c, 1'b0, 8'h00);
    endtask

    task automatic send_byte(input logic [7:0] d);
        tick(1'b0, 1'b0, CMD_NOP, 1'b1, d);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, CMD_NOP, 1'b0, 8'h00);
        tick(1'b1, 1'b0, CMD_NOP, 1'b0, 8'h00);
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic expect_write(input string tag, input int addr, input logic [31:0] data);
        check({tag, "_present"}, 64'(log_addr.size() > 0), 64'd1);
        if (log_addr.size() > 0) begin
            check({tag, "_addr"}, 64'(log_addr.pop_front()), 64'(addr));
            check({tag, "_data"}, 64'(log_data.pop_front()), 64'(data));
        end
    endtask

    logic [7:0] prog[8];
    int         rate;
    bit         r_r, r_cv, r_dv;
    logic [2:0] r_c;

    initial begin
        // Reset
        do_reset();
        check("rst_state",   64'(bus.state),      64'd0);
        check("rst_cpu_rst", 64'(bus.cpu_rst),    64'd1);
        check("rst_cpu_en",  64'(bus.cpu_en),     64'd0);
        check("rst_we",      64'(bus.imem_we),    64'd0);
        check("rst_cycles",  64'(bus.run_cycles), 64'd0);

        // Two full words, then RUN
        prog = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_cmd(CMD_LOAD);
        for (int i = 0; i < 8; i++) send_byte(prog[i]);
        check("load2_nwrites", 64'(log_addr.size()), 64'd2);
        expect_write("load2_w0", 0, 32'h00500013);
        expect_write("load2_w1", 1, 32'h00100093);
        send_cmd(CMD_RUN);
        check("run_cpu_rst", 64'(bus.cpu_rst), 64'd0);
        check("run_cpu_en",  64'(bus.cpu_en),  64'd1);

        // Partial word flushed by RUN on the same cycle as the last byte
        do_reset();
        send_cmd(CMD_LOAD);
        send_byte(8'hAA);
        send_byte(8'hBB);
        tick(1'b0, 1'b1, CMD_RUN, 1'b1, 8'hCC);
        check("flush_state", 64'(bus.state), 64'd2);
        check("flush_nwrites", 64'(log_addr.size()), 64'd1);
        expect_write("flush_w0", 0, 32'h00CCBBAA);
        idle(1);
        check("flush_released", 64'(bus.cpu_rst), 64'd0);

        // Run 10 cycles, halt, single step, then saturation
        do_reset();
        send_cmd(CMD_RUN);
        idle(9);
        send_cmd(CMD_HALT);
        check("halt_cycles", 64'(bus.run_cycles), 64'd10);
        check("halt_cpu_en", 64'(bus.cpu_en),     64'd0);
        send_cmd(CMD_STEP);
        check("step_cpu_en", 64'(bus.cpu_en), 64'd1);
        check("step_state",  64'(bus.state),  64'd4);
        idle(1);
        check("step_done_en",     64'(bus.cpu_en),     64'd0);
        check("step_done_cycles", 64'(bus.run_cycles), 64'd11);
        check("step_done_state",  64'(bus.state),      64'd3);
        send_cmd(CMD_RUN);
        idle(70);
        send_cmd(CMD_HALT);
        check("sat_cycles", 64'(bus.run_cycles), 64'(CNT_MAX));

        // IMEM full: 17 bytes into a 4-word memory
        do_reset();
        send_cmd(CMD_LOAD);
        for (int i = 0; i < 17; i++) send_byte(8'(i + 1));
        check("ovf_nwrites", 64'(log_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            expect_write("ovf_w", i, {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)});
        check("ovf_flag", 64'(bus.overflow), 64'd1);
        send_cmd(CMD_RUN);
        check("ovf_no_pad", 64'(log_addr.size()), 64'd0);
        send_cmd(CMD_LOAD);
        check("ovf_cleared", 64'(bus.overflow), 64'd0);

        // Reset in the middle of a word
        do_reset();
        send_cmd(CMD_LOAD);
        send_byte(8'h01);
        send_byte(8'h02);
        tick(1'b1, 1'b0, CMD_NOP, 1'b0, 8'h00);
        check("midrst_nwrites", 64'(log_addr.size()), 64'd0);
        send_cmd(CMD_LOAD);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        expect_write("midrst_w0", 0, 32'h44332211);

        // Randomized traffic, checked every cycle against the model
        for (int seg = 0; seg < 6; seg++) begin
            rate = $urandom_range(2, 40);
            for (int i = 0; i < 500; i++) begin
                r_r  = ($urandom_range(0, 299) == 0);
                r_cv = ($urandom_range(0, rate - 1) == 0);
                r_c  = 3'($urandom_range(0, 7));
                if (m_state == 1 && r_c == CMD_LOAD) r_c = CMD_NOP;
                r_dv = ($urandom_range(0, 1) == 1);
                tick(r_r, r_cv, r_c, r_dv, 8'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences the pipelined RV32 core for bring-up through the 8-bit pin interface.
- Accepts byte-wide commands and program bytes, assembles little-endian 32-bit words and writes them into instruction memory while the core is held in reset.
- Then releases the core and supports RUN, HALT and single-STEP, with a cycle counter readable on the output pins.
- Sits between the top-level pin wrapper and pipelined_risc_v_cpu / its IMEM write port.

Parameters:
- WIDTH, 32, instruction/data word width; the assembler packs WIDTH/8 bytes per word.
- IMEM_AW, 6, IMEM word-address width (2^IMEM_AW words).
- CNT_W, 16, width of the run-cycle counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command strobe, one cycle per command.
- cmd  in  3  command code: 0 NOP, 1 LOAD, 2 RUN, 3 HALT, 4 STEP, 5–7 ignored.
- data_valid  in  1  program-byte strobe.
- data_in  in  8  program byte.
- imem_we  out  1  IMEM write enable, single-cycle pulse.
- imem_waddr  out  IMEM_AW  IMEM word address.
- imem_wdata  out  WIDTH  IMEM write data.
- cpu_rst  out  1  core reset, active-high.
- cpu_en  out  1  core pipeline advance enable (low = whole pipeline stalls).
- state  out  3  encoded FSM state.
- overflow  out  1  sticky: IMEM full and a byte was dropped.
- run_cycles  out  CNT_W  number of cycles with cpu_en=1, saturating.

Behaviour:
- Reset values:
  - state=IDLE, cpu_rst=1, cpu_en=0, imem_we=0, imem_waddr=0, imem_wdata=0, overflow=0, run_cycles=0.
  - Internal byte index=0.
- All outputs are registered. A command or byte sampled at edge N takes effect on the outputs after edge N.
- State encoding: IDLE=0, LOAD=1, RUN=2, HALT=3, STEP=4.
- IDLE: cpu_rst=1, cpu_en=0.
  - LOAD -> LOAD.
  - RUN -> RUN.
  - HALT/STEP are ignored.
- LOAD: cpu_rst=1, cpu_en=0. On entry: word address=0, byte index=0, overflow cleared, run_cycles cleared.
  - Each data_valid byte fills lane byte_index (little-endian: byte 0 -> bits 7:0).
  - After the 4th byte, imem_we=1 for exactly one cycle, with imem_wdata = assembled word and imem_waddr = current address.
  - The address then increments and the byte index returns to 0.
- Address full: after writing address 2^IMEM_AW-1 the address does not wrap. Further bytes are dropped and overflow is set (sticky until next LOAD or rst).
- RUN issued in LOAD:
  - If byte index>0, the partial word is written zero-padded in the upper lanes (one imem_we pulse), then RUN is entered.
  - The pad write and the RUN transition occur on the same edge.
- Simultaneous data_valid and cmd_valid in LOAD: the byte is consumed first and is included in any pad/flush. A 4th byte plus RUN yields a single full-word write, no extra pad write.
- data_valid outside LOAD is ignored.
- RUN: cpu_rst=0, cpu_en=1; run_cycles increments each cycle and saturates at all-ones.
  - HALT -> HALT.
  - LOAD -> LOAD (core re-reset, mid-run abort allowed).
- HALT: cpu_rst=0, cpu_en=0; the core keeps its architectural state.
  - RUN -> RUN.
  - STEP -> STEP.
  - LOAD -> LOAD.
- STEP: cpu_en=1 for exactly one cycle, run_cycles+1, then HALT unconditionally. Commands arriving during the STEP cycle are ignored.
- RUN in RUN, HALT in HALT, STEP in RUN, and undefined codes are no-ops.
- rst asserted in any state, including mid-word in LOAD: immediate return to reset values next edge. A partially assembled word is discarded, not written.
- imem_we is never high while cpu_rst=0.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - command code constants CMD_NOP, CMD_LOAD, CMD_RUN, CMD_HALT, CMD_STEP;
  - state encoding constants ST_IDLE, ST_LOAD, ST_RUN, ST_HALT, ST_STEP, also used by the top wrapper for pin debug.
- One sub-module: byte_word_assembler. It covers byte lane insertion, the byte index, flush/zero-pad, and the write pulse, with inputs byte/valid/flush and outputs word/we.
- The FSM, address counter and run_cycles counter stay in cpu_run_controller.

Test Plan:
- Reset check: assert rst 2 cycles -> state=0, cpu_rst=1, cpu_en=0, imem_we=0, run_cycles=0.
- Load two words: LOAD, then bytes 13,00,50,00,93,00,10,00 -> imem_we pulses twice: addr0=0x00500013, addr1=0x00100093. Then RUN -> cpu_rst=0, cpu_en=1 next cycle.
- Partial flush: LOAD, bytes AA,BB,CC, RUN on the same cycle as CC -> one write addr0=0x00CCBBAA, then state=RUN.
- Halt/step: RUN 10 cycles, HALT -> run_cycles=10, cpu_en=0. STEP -> cpu_en high exactly one cycle, run_cycles=11, state returns to HALT.
- Overflow: with IMEM_AW=2, LOAD then 17 bytes -> 4 writes (addr 0..3), overflow=1, no 5th write. A new LOAD clears overflow.
- Reset mid-word: LOAD, bytes 01,02, rst -> no imem_we. After reset, LOAD, 4 bytes -> writes addr0.
